softmax_controller: RTL

- Sequencer for one softmax evaluation over up to 2^INPUTMAX-1 signed samples.
- Captures the input stream into an internal buffer and tracks the running maximum during capture.
- Schedules one request at a time to a shared exponent unit (argument x-max), then to a shared divider (exp/sum), and streams the quotients out in input order.
- Sits between the sample source and the arithmetic units; those units are external and attached through valid/ready handshakes.

---
 rtl/softmax_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/softmax_controller.sv
// Softmax sequencer: buffers the samples, then drives an external exp unit
// and divider one request at a time and streams the quotients out in order.
module softmax_controller #(
    parameter int DATALENGTH = 32,
    parameter int INPUTMAX   = 5
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Start,
    input  logic [INPUTMAX-1:0]            N,
    input  logic                           InValid,
    output logic                           InReady,
    input  logic signed [DATALENGTH-1:0]   Datain,
    output logic                           ExpValid,
    input  logic                           ExpReady,
    output logic signed [DATALENGTH-1:0]   ExpArg,
    input  logic                           ExpRspValid,
    input  logic [DATALENGTH-1:0]          ExpRsp,
    output logic                           DivValid,
    input  logic                           DivReady,
    output logic [DATALENGTH-1:0]          DivNum,
    output logic [DATALENGTH+INPUTMAX-1:0] DivDen,
    input  logic                           DivRspValid,
    input  logic [DATALENGTH-1:0]          DivRsp,
    output logic                           OutValid,
    input  logic                           OutReady,
    output logic [DATALENGTH-1:0]          Dataout,
    output logic                           Busy,
    output logic                           Done
);

    localparam int DEPTH = 1 << INPUTMAX;
    localparam int SW    = DATALENGTH + INPUTMAX;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] EXP_REQ  = 3'd2;
    localparam logic [2:0] EXP_WAIT = 3'd3;
    localparam logic [2:0] DIV_REQ  = 3'd4;
    localparam logic [2:0] DIV_WAIT = 3'd5;
    localparam logic [2:0] OUT      = 3'd6;

    localparam logic [INPUTMAX-1:0]   ONE  = {{(INPUTMAX-1){1'b0}}, 1'b1};
    localparam logic [DATALENGTH-1:0] SMIN = {1'b1, {(DATALENGTH-1){1'b0}}};
    localparam logic [DATALENGTH-1:0] SMAX = ~SMIN;

    logic [2:0]                   state;
    logic [INPUTMAX-1:0]          idx;
    logic [INPUTMAX-1:0]          lastn;
    logic signed [DATALENGTH-1:0] mx;
    logic [SW-1:0]                sum;
    logic [DATALENGTH-1:0]        dout;
    logic                         done_q;

    logic [DATALENGTH-1:0] mem [DEPTH];
    logic [DATALENGTH-1:0] cur;
    logic                  mem_we;
    logic [DATALENGTH-1:0] mem_wd;
    logic [DATALENGTH:0]   diff;
    logic [DATALENGTH-1:0] sat;
    logic                  last;

    assign cur  = mem[idx];
    assign last = (idx == lastn);

    // One extra bit so x-max can never wrap; clamp back into range.
    assign diff = {cur[DATALENGTH-1], cur} - {mx[DATALENGTH-1], mx};

    always_comb begin
        sat = diff[DATALENGTH-1:0];
        if (diff[DATALENGTH] != diff[DATALENGTH-1])
            sat = diff[DATALENGTH] ? SMIN : SMAX;
    end

    // The buffer holds samples first, then is overwritten in place by exp results.
    assign mem_we = (state == LOAD && InValid) || (state == EXP_WAIT && ExpRspValid);
    assign mem_wd = (state == LOAD) ? Datain : ExpRsp;

    always_ff @(posedge Clock) begin
        if (mem_we)
            mem[idx] <= mem_wd;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            idx    <= '0;
            lastn  <= '0;
            mx     <= '0;
            sum    <= '0;
            dout   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (N != '0) begin
                            lastn <= N - ONE;
                            idx   <= '0;
                            sum   <= '0;
                            state <= LOAD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (InValid) begin
                        if (idx == '0 || Datain > mx)
                            mx <= Datain;
                        if (last) begin
                            idx   <= '0;
                            state <= EXP_REQ;
                        end else begin
                            idx <= idx + ONE;
                        end
                    end
                end
                EXP_REQ: begin
                    if (ExpReady)
                        state <= EXP_WAIT;
                end
                EXP_WAIT: begin
                    if (ExpRspValid) begin
                        sum <= sum + SW'(ExpRsp);
                        if (last) begin
                            idx   <= '0;
                            state <= DIV_REQ;
                        end else begin
                            idx   <= idx + ONE;
                            state <= EXP_REQ;
                        end
                    end
                end
                DIV_REQ: begin
                    if (DivReady)
                        state <= DIV_WAIT;
                end
                DIV_WAIT: begin
                    if (DivRspValid) begin
                        dout  <= DivRsp;
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (OutReady) begin
                        if (last) begin
                            idx    <= '0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            idx   <= idx + ONE;
                            state <= DIV_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign InReady  = (state == LOAD);
    assign ExpValid = (state == EXP_REQ);
    assign ExpArg   = ExpValid ? sat : '0;
    assign DivValid = (state == DIV_REQ);
    assign DivNum   = DivValid ? cur : '0;
    assign DivDen   = DivValid ? sum : '0;
    assign OutValid = (state == OUT);
    assign Dataout  = dout;
    assign Busy     = (state != IDLE);
    assign Done     = done_q;

endmodule
